// File: rtl/seven_seg_scan_decoder.sv
// ============================================================================
// seven_seg_scan_decoder : readback of a scanned, active-low 7-segment display
// Rev 1.0 : first release
// ============================================================================
`default_nettype none

module seven_seg_scan_decoder #(
  parameter int STABLE_CYCLES = 2,
  parameter int FRAME_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit_select,
  input  logic [6:0]  led_select,
  output logic [15:0] value,
  output logic [3:0]  blank_mask,
  output logic [3:0]  minus_mask,
  output logic [3:0]  err_mask,
  output logic        frame_valid,
  output logic        value_changed,
  output logic        sel_error,
  output logic        timeout
);

  localparam int              TW       = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [7:0]      STABLE_N = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0]   TMO_LAST = TW'(FRAME_TIMEOUT - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [3:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [0:0]    state_q, state_d;
  logic [3:0]    trk_sel_q, trk_sel_d;
  logic [6:0]    trk_seg_q, trk_seg_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    collected_q, collected_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   stg_val_q, stg_val_d;
  logic [3:0]    stg_blank_q, stg_blank_d;
  logic [3:0]    stg_minus_q, stg_minus_d;
  logic [3:0]    stg_err_q, stg_err_d;
  logic [15:0]   value_q, value_d;
  logic [3:0]    blank_q, blank_d;
  logic [3:0]    minus_q, minus_d;
  logic [3:0]    err_q, err_d;
  logic          frame_valid_q, frame_valid_d;
  logic          value_changed_q, value_changed_d;
  logic          sel_error_q, sel_error_d;
  logic          timeout_q, timeout_d;

  logic          sel_idle, sel_legal, sel_illegal;
  logic          capture;
  logic [1:0]    dig_idx;
  logic [3:0]    nibble;
  logic          dec_ok, pat_blank, pat_minus;
  logic          do_complete, tmo_hit, capture_eff;

  assign sel_d       = digit_select;
  assign seg_d       = led_select;
  assign sel_idle    = (sel_q == 4'hF);
  assign sel_legal   = $onehot(~sel_q);
  assign sel_illegal = !sel_idle && !sel_legal;

  // State register (also holds all datapath flops)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q           <= 4'hF;
      seg_q           <= 7'h7F;
      state_q         <= IDLE;
      trk_sel_q       <= 4'hF;
      trk_seg_q       <= 7'h7F;
      cnt_q           <= 8'd0;
      collected_q     <= 4'd0;
      tmo_q           <= '0;
      stg_val_q       <= 16'd0;
      stg_blank_q     <= 4'd0;
      stg_minus_q     <= 4'd0;
      stg_err_q       <= 4'd0;
      value_q         <= 16'd0;
      blank_q         <= 4'd0;
      minus_q         <= 4'd0;
      err_q           <= 4'd0;
      frame_valid_q   <= 1'b0;
      value_changed_q <= 1'b0;
      sel_error_q     <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      sel_q           <= sel_d;
      seg_q           <= seg_d;
      state_q         <= state_d;
      trk_sel_q       <= trk_sel_d;
      trk_seg_q       <= trk_seg_d;
      cnt_q           <= cnt_d;
      collected_q     <= collected_d;
      tmo_q           <= tmo_d;
      stg_val_q       <= stg_val_d;
      stg_blank_q     <= stg_blank_d;
      stg_minus_q     <= stg_minus_d;
      stg_err_q       <= stg_err_d;
      value_q         <= value_d;
      blank_q         <= blank_d;
      minus_q         <= minus_d;
      err_q           <= err_d;
      frame_valid_q   <= frame_valid_d;
      value_changed_q <= value_changed_d;
      sel_error_q     <= sel_error_d;
      timeout_q       <= timeout_d;
    end
  end

  // Next-state: debounce tracking and single-shot capture strobe
  always_comb begin
    state_d   = state_q;
    trk_sel_d = trk_sel_q;
    trk_seg_d = trk_seg_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    if (!sel_legal) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (state_q == TRACK && sel_q == trk_sel_q && seg_q == trk_seg_q) begin
      if (cnt_q < STABLE_N) begin
        cnt_d   = cnt_q + 8'd1;
        capture = ((cnt_q + 8'd1) == STABLE_N);
      end
    end else begin
      state_d   = TRACK;
      trk_sel_d = sel_q;
      trk_seg_d = seg_q;
      cnt_d     = 8'd1;
      capture   = (STABLE_N == 8'd1);
    end
  end

  always_comb begin
    dig_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!sel_q[i]) dig_idx = 2'(i);
    end
  end

  always_comb begin
    nibble = 4'd0;
    dec_ok = 1'b1;
    case (~seg_q)
      7'h3F: nibble = 4'h0;
      7'h06: nibble = 4'h1;
      7'h5B: nibble = 4'h2;
      7'h4F: nibble = 4'h3;
      7'h66: nibble = 4'h4;
      7'h6D: nibble = 4'h5;
      7'h7D: nibble = 4'h6;
      7'h07: nibble = 4'h7;
      7'h7F: nibble = 4'h8;
      7'h6F: nibble = 4'h9;
      7'h77: nibble = 4'hA;
      7'h7C: nibble = 4'hB;
      7'h39: nibble = 4'hC;
      7'h5E: nibble = 4'hD;
      7'h79: nibble = 4'hE;
      7'h71: nibble = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  assign pat_blank   = (seg_q == 7'h7F);
  assign pat_minus   = (seg_q == 7'h3F);
  assign do_complete = (collected_q == 4'hF);
  assign tmo_hit     = !do_complete && (collected_q != 4'd0) && (tmo_q == TMO_LAST);
  // The timeout discards the partial frame, so a coincident capture is lost
  assign capture_eff = capture && !tmo_hit;

  // Output/datapath: staging, frame assembly, timeout and status pulses
  always_comb begin
    stg_val_d       = stg_val_q;
    stg_blank_d     = stg_blank_q;
    stg_minus_d     = stg_minus_q;
    stg_err_d       = stg_err_q;
    collected_d     = do_complete ? 4'd0 : collected_q;
    tmo_d           = (do_complete || collected_q == 4'd0 || tmo_hit) ? '0 : tmo_q + 1'b1;
    value_d         = value_q;
    blank_d         = blank_q;
    minus_d         = minus_q;
    err_d           = err_q;
    frame_valid_d   = 1'b0;
    value_changed_d = 1'b0;
    sel_error_d     = sel_illegal;
    timeout_d       = tmo_hit;

    if (tmo_hit) begin
      collected_d = 4'd0;
      stg_val_d   = 16'd0;
      stg_blank_d = 4'd0;
      stg_minus_d = 4'd0;
      stg_err_d   = 4'd0;
    end

    if (do_complete) begin
      value_d         = stg_val_q;
      blank_d         = stg_blank_q;
      minus_d         = stg_minus_q;
      err_d           = stg_err_q;
      frame_valid_d   = 1'b1;
      value_changed_d = (stg_val_q != value_q);
    end

    if (capture_eff) begin
      stg_val_d[{dig_idx, 2'b00} +: 4] = (pat_blank || pat_minus || !dec_ok) ? 4'd0 : nibble;
      stg_blank_d[dig_idx]             = pat_blank;
      stg_minus_d[dig_idx]             = pat_minus;
      stg_err_d[dig_idx]               = !pat_blank && !pat_minus && !dec_ok;
      collected_d[dig_idx]             = 1'b1;
    end
  end

  assign value         = value_q;
  assign blank_mask    = blank_q;
  assign minus_mask    = minus_q;
  assign err_mask      = err_q;
  assign frame_valid   = frame_valid_q;
  assign value_changed = value_changed_q;
  assign sel_error     = sel_error_q;
  assign timeout       = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
// ============================================================================
// tb_seven_seg_scan_decoder : scoreboard bench for the 7-segment scan decoder
// Rev 1.0 : first release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  digit_select = 4'hF;
  logic [6:0]  led_select = 7'h7F;
  logic [15:0] value;
  logic [3:0]  blank_mask, minus_mask, err_mask;
  logic        frame_valid, value_changed, sel_error, timeout;

  seven_seg_scan_decoder #(.STABLE_CYCLES(2), .FRAME_TIMEOUT(1024)) dut (
    .clk           (clk),
    .reset         (reset),
    .digit_select  (digit_select),
    .led_select    (led_select),
    .value         (value),
    .blank_mask    (blank_mask),
    .minus_mask    (minus_mask),
    .err_mask      (err_mask),
    .frame_valid   (frame_valid),
    .value_changed (value_changed),
    .sel_error     (sel_error),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  b;
    logic [3:0]  m;
    logic [3:0]  e;
    logic        ch;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int frame_cnt = 0;
  int selerr_cnt = 0;
  int tmo_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      if (frame_valid) begin
        frame_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_frame_queue_depth", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("frame_value", 32'(value), 32'(e.v));
          check("frame_blank_mask", 32'(blank_mask), 32'(e.b));
          check("frame_minus_mask", 32'(minus_mask), 32'(e.m));
          check("frame_err_mask", 32'(err_mask), 32'(e.e));
          check("frame_value_changed", 32'(value_changed), 32'(e.ch));
        end
      end
      if (sel_error) selerr_cnt++;
      if (timeout)   tmo_cnt++;
    end
  end

  task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
    digit_select = s;
    led_select   = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0, input int n);
    hold(4'b0111, s3, n);
    hold(4'b1011, s2, n);
    hold(4'b1101, s1, n);
    hold(4'b1110, s0, n);
    hold(4'hF, 7'h7F, 2);
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] b, input logic [3:0] m,
                      input logic [3:0] e, input logic ch);
    exp_t x;
    x.v = v; x.b = b; x.m = m; x.e = e; x.ch = ch;
    sb.push_back(x);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin : stim
    int k;
    int fc;
    #1;
    check("rst_value", 32'(value), 32'd0);
    check("rst_masks", {20'd0, blank_mask, minus_mask, err_mask}, 32'd0);
    check("rst_pulses", {28'd0, frame_valid, value_changed, sel_error, timeout}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Digits 1,2,3,4 on positions 3..0
    push(16'h1234, 4'd0, 4'd0, 4'd0, 1'b1);
    scan(7'h79, 7'h24, 7'h30, 7'h19, 3);
    wait_done("frame_1234_seen");

    push(16'h1234, 4'd0, 4'd0, 4'd0, 1'b0);
    scan(7'h79, 7'h24, 7'h30, 7'h19, 3);
    wait_done("frame_1234_repeat_seen");

    // Only digit 3 is stable; the rest flash for a single cycle
    fc = frame_cnt;
    hold(4'b0111, 7'h79, 3);
    hold(4'b1011, 7'h24, 1);
    hold(4'b1101, 7'h30, 1);
    hold(4'b1110, 7'h19, 1);
    hold(4'hF, 7'h7F, 1);
    k = 0;
    while (tmo_cnt == 0 && k < 1200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_pulse_count", 32'(tmo_cnt), 32'd1);
    check("timeout_window", 32'(k >= 1000 && k <= 1030), 32'd1);
    check("timeout_keeps_value", 32'(value), 32'h1234);
    check("timeout_no_frame", 32'(frame_cnt), 32'(fc));

    // Illegal select in the middle of digit 1 -> 5,6,7,8
    push(16'h5678, 4'd0, 4'd0, 4'd0, 1'b1);
    hold(4'b0111, 7'h12, 3);
    hold(4'b1011, 7'h02, 3);
    hold(4'b1101, 7'h78, 1);
    hold(4'b0011, 7'h78, 1);
    hold(4'b1101, 7'h78, 3);
    hold(4'b1110, 7'h00, 3);
    hold(4'hF, 7'h7F, 2);
    wait_done("frame_5678_after_sel_error");
    check("sel_error_count", 32'(selerr_cnt), 32'd1);

    // Minus / blank / 8 / 0, then the same with an undecodable digit 0
    push(16'h0080, 4'b0100, 4'b1000, 4'd0, 1'b1);
    scan(7'h3F, 7'h7F, 7'h00, 7'h40, 3);
    wait_done("frame_masks_seen");
    push(16'h0080, 4'b0100, 4'b1000, 4'b0001, 1'b0);
    scan(7'h3F, 7'h7F, 7'h00, 7'h7E, 3);
    wait_done("frame_err_seen");

    // Reset after three captured digits
    fc = frame_cnt;
    hold(4'b0111, 7'h79, 3);
    hold(4'b1011, 7'h24, 3);
    hold(4'b1101, 7'h30, 3);
    reset = 1'b0;
    digit_select = 4'hF;
    led_select = 7'h7F;
    #1;
    check("midrst_value_zero", 32'(value), 32'd0);
    check("midrst_masks_zero", {20'd0, blank_mask, minus_mask, err_mask}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hold(4'b1110, 7'h19, 3);
    hold(4'hF, 7'h7F, 10);
    check("midrst_partial_no_frame", 32'(frame_cnt), 32'(fc));
    push(16'h1234, 4'd0, 4'd0, 4'd0, 1'b1);
    scan(7'h79, 7'h24, 7'h30, 7'h19, 3);
    wait_done("frame_after_reset_seen");
    check("total_frames", 32'(frame_cnt), 32'(fc + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
